wb_commit: RTL
==============

Name: wb_commit

Overview:
- In-order writeback/commit unit; the receiving end of the issue stage's register-file write interface.
- Queues each write request issued (destination address plus source select: ALU or LSU).
- Accepts the matching result from the ALU or LSU in issue order and drives the single register-file write port.
- Gives decode a read-after-write hazard indication for both source operands.

Parameters:
- DEPTH, 4, number of outstanding write tags; power of two, 2..16.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_rf_w_i  in  1  issue pushes a write tag this cycle.
- rf_waddr_i  in  AW  destination register of the pushed tag.
- rf_soursel_i  in  1  source of the pushed tag: 0 ALU, 1 LSU.
- tag_ready_o  out  1  tag queue can accept a push.
- alu_valid_i  in  1  ALU result available.
- alu_result_i  in  DW  ALU result.
- alu_ready_o  out  1  ALU result consumed this cycle.
- lsu_valid_i  in  1  LSU load data available.
- lsu_rdata_i  in  DW  LSU load data.
- lsu_ready_o  out  1  LSU data consumed this cycle.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  AW  register-file write address.
- rf_wdata_o  out  DW  register-file write data.
- rf_raddr_a_i  in  AW  decode operand A address, for hazard check.
- rf_raddr_b_i  in  AW  decode operand B address, for hazard check.
- hazard_a_o  out  1  operand A has a pending write.
- hazard_b_o  out  1  operand B has a pending write.
- empty_o  out  1  no outstanding tags.

Behaviour:
- Reset (rst_ni low, asynchronous): queue emptied and pointers zeroed.
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - tag_ready_o=1, empty_o=1, alu_ready_o=0, lsu_ready_o=0, hazard_a_o=0, hazard_b_o=0.
- Reset mid-operation discards every pending tag; in-flight results are not written.
- Tag queue:
  - Circular FIFO of {waddr, soursel}, DEPTH entries, with a count register of width clog2(DEPTH)+1.
  - Push when req_rf_w_i && tag_ready_o; tag_ready_o = !full (registered count, no same-cycle pop bypass).
  - A push while full is ignored and must trigger an assertion.
  - Pointers wrap modulo DEPTH.
- Result acceptance, combinational from head state:
  - alu_ready_o = !empty && head.soursel==0 && alu_valid_i.
  - lsu_ready_o = !empty && head.soursel==1 && lsu_valid_i.
  - At most one ready is high per cycle.
  - A valid result from the non-head source is held off (ready=0) until its tag reaches the head.
- Pop: occurs the same cycle a ready is high.
- Simultaneous push and pop: count unchanged and both pointers advance; legal at any fill level below full.
- Write latency: exactly 1 cycle. Result accepted in cycle N gives rf_we_o=1 in cycle N+1 for one cycle, with rf_waddr_o = head.waddr and rf_wdata_o = the accepted data.
- x0 handling: if head.waddr==0, the result is consumed and popped but rf_we_o stays 0. rf_waddr_o and rf_wdata_o hold their last values when rf_we_o=0.
- Hazard check (combinational):
  - hazard_a_o = (rf_raddr_a_i != 0) && any valid queue entry has waddr == rf_raddr_a_i; hazard_b_o likewise for rf_raddr_b_i.
  - The entry popped in the current cycle still counts as pending.
  - The write registered for cycle N+1 does not count, since the RF is written at N+1 and decode reads after.
- empty_o = (count==0).
- Sustained throughput: one commit per cycle.

Decomposition:
- pkg gains:
  - typedef enum logic {WB_SRC_ALU=1'b0, WB_SRC_LSU=1'b1} wb_src_sel.
  - typedef struct packed {logic [4:0] waddr; wb_src_sel src;} wb_tag_t.
  - localparam WB_DEPTH = 4.
- One sub-module, wb_tag_fifo: a generic FIFO of wb_tag_t exposing the per-entry valid/waddr vector for the hazard compare.
- wb_commit itself holds the head arbitration, the output register and the hazard logic.

Test Plan:
- Single ALU write: push {x10, ALU}; next cycle alu_valid_i=1, result 0x00000055. Required: alu_ready_o=1 that cycle; following cycle rf_we_o=1, rf_waddr_o=10, rf_wdata_o=0x00000055; empty_o=1 afterwards.
- Ordering: push {x5, LSU} then {x6, ALU}; ALU valid first with 0x11, LSU valid two cycles later with 0x22. Required: alu_ready_o stays 0 until the LSU commit; writes occur x5=0x22 then x6=0x11, in consecutive cycles.
- Full queue: push 4 tags without results. Required: tag_ready_o=0 and a fifth push is ignored. Then push and pop in the same cycle at count 3: count stays 3.
- x0 discard: push {x0, ALU}, ALU result 0xFFFFFFFF. Required: alu_ready_o=1, rf_we_o never rises, queue pops.
- Hazard: push {x7, ALU}; set rf_raddr_a_i=7, rf_raddr_b_i=0. Required: hazard_a_o=1, hazard_b_o=0; after commit, hazard_a_o=0 in the rf_we_o cycle.
- Reset mid-operation: 3 tags pending, drop rst_ni asynchronously between clock edges. Required: all outputs at reset values immediately; post-reset results are not accepted (ready=0).

Source files
------------

// File: rtl/wb_commit_pkg.sv
// Shared types and defaults for the in-order writeback/commit unit.
package wb_commit_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_sel;

  typedef struct packed {
    logic [4:0] waddr;
    wb_src_sel  src;
  } wb_tag_t;

endpackage

// File: rtl/wb_tag_fifo.sv
// Circular FIFO of write tags; exposes per-entry valid/waddr so the
// owner can run a hazard compare against every outstanding write.
module wb_tag_fifo
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_tag_t               push_tag,
  input  logic                  pop,
  output wb_tag_t               head_tag,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH-1:0][4:0] entry_waddr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wb_tag_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW-1:0] off;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_tag = mem[rd_ptr];

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An entry is live when its distance from the head is below the fill count.
  always_comb begin
    off         = '0;
    entry_valid = '0;
    entry_waddr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
      entry_waddr[i] = mem[i].waddr;
    end
  end

endmodule

// File: rtl/wb_commit.sv
// In-order writeback/commit: queues issued write tags, accepts ALU/LSU
// results in issue order, drives the RF write port and flags RAW hazards.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_rf_w_i,
  input  logic [AW-1:0] rf_waddr_i,
  input  logic          rf_soursel_i,
  output logic          tag_ready_o,
  input  logic          alu_valid_i,
  input  logic [DW-1:0] alu_result_i,
  output logic          alu_ready_o,
  input  logic          lsu_valid_i,
  input  logic [DW-1:0] lsu_rdata_i,
  output logic          lsu_ready_o,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o,
  input  logic [AW-1:0] rf_raddr_a_i,
  input  logic [AW-1:0] rf_raddr_b_i,
  output logic          hazard_a_o,
  output logic          hazard_b_o,
  output logic          empty_o
);

  wb_tag_t               push_tag;
  wb_tag_t               head_tag;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DW-1:0]         pop_data;
  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH-1:0][4:0] entry_waddr;

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high; ready never waits on anything but registered queue state and the
  // producer's own valid, and a producer holds valid/data until it sees ready.
  assign push_tag    = '{waddr: rf_waddr_i, src: wb_src_sel'(rf_soursel_i)};
  assign tag_ready_o = !full;
  assign push        = req_rf_w_i && tag_ready_o;

  assign alu_ready_o = !empty && (head_tag.src == WB_SRC_ALU) && alu_valid_i;
  assign lsu_ready_o = !empty && (head_tag.src == WB_SRC_LSU) && lsu_valid_i;
  assign pop         = alu_ready_o || lsu_ready_o;
  assign pop_data    = lsu_ready_o ? lsu_rdata_i : alu_result_i;
  assign empty_o     = empty;

  wb_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .push        (push),
    .push_tag    (push_tag),
    .pop         (pop),
    .head_tag    (head_tag),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_waddr (entry_waddr)
  );

  // Writes to x0 are consumed but never reach the RF; address/data hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= pop && (head_tag.waddr != '0);
      if (pop && (head_tag.waddr != '0)) begin
        rf_waddr_o <= head_tag.waddr;
        rf_wdata_o <= pop_data;
      end
    end
  end

  // The registered write lands before decode reads, so only queued tags count.
  always_comb begin
    hazard_a_o = 1'b0;
    hazard_b_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_waddr[i] == rf_raddr_a_i)) hazard_a_o = 1'b1;
      if (entry_valid[i] && (entry_waddr[i] == rf_raddr_b_i)) hazard_b_o = 1'b1;
    end
    if (rf_raddr_a_i == '0) hazard_a_o = 1'b0;
    if (rf_raddr_b_i == '0) hazard_b_o = 1'b0;
  end

  push_while_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req_rf_w_i && !tag_ready_o))
    else $warning("wb_commit: tag push while queue full was dropped");

  one_ready_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(alu_ready_o && lsu_ready_o));

endmodule
